// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants.
// Imported by the fetch unit and its prefetch queue.
package fetch_unit_pkg;

  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;
  localparam logic [31:0] NopInst        = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIssue,
    StWait,
    StDrop
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry {pc,inst} prefetch FIFO with synchronous flush.
// Pushes are only visible at the head from the following cycle.
module fetch_queue
  import fetch_unit_pkg::*;
(
  input  logic        CLK,
  input  logic        RES,
  input  logic        flush_i,
  input  logic        push_i,
  input  logic [31:0] push_pc_i,
  input  logic [31:0] push_inst_i,
  input  logic        pop_i,
  output logic [31:0] head_pc_o,
  output logic [31:0] head_inst_o,
  output logic [1:0]  count_o
);

  fetch_entry_t entry_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign do_push = push_i && (count_q != 2'd2);
  assign do_pop  = pop_i && (count_q != 2'd0);

  always_ff @(posedge CLK) begin
    if (RES || flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Payload needs no reset; count gates its visibility.
  always_ff @(posedge CLK) begin
    if (do_push && !RES && !flush_i) begin
      entry_q[wr_ptr_q] <= '{pc: push_pc_i, inst: push_inst_i};
    end
  end

  assign head_pc_o   = entry_q[rd_ptr_q].pc;
  assign head_inst_o = entry_q[rd_ptr_q].inst;
  assign count_o     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem requests, prefetch
// queue and the IF/ID register pair, with branch redirect and bubble injection.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DefaultResetPc,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        HLT,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc,
  input  logic        IHLT,
  input  logic [31:0] ihlt_pc,
  output logic [31:0] IADDR,
  output logic        IREQ,
  input  logic [31:0] IDATA,
  input  logic        IACK,
  output logic [31:0] IF_ID_pc,
  output logic [31:0] IF_ID_inst
);

  localparam logic [1:0] QFull = 2'(QDEPTH);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  iaddr_q;
  logic         ireq_q;
  logic [31:0]  if_pc_q;
  logic [31:0]  if_inst_q;

  logic         redirect;
  logic [31:0]  target;
  logic         q_push;
  logic         q_pop;
  logic         q_empty;
  logic [1:0]   q_count;
  logic [31:0]  head_pc;
  logic [31:0]  head_inst;
  logic         can_issue;

  assign redirect = branch_taken | IHLT;
  assign target   = word_align(branch_taken ? branch_pc : ihlt_pc);
  assign q_empty  = (q_count == 2'd0);
  assign q_pop    = !HLT && !redirect && !q_empty;
  assign q_push   = (state_q == StWait) && IACK && !redirect;
  // A pop this cycle frees its slot for a request issued on the same edge.
  assign can_issue = !redirect && ((q_count - {1'b0, q_pop}) < QFull);

  fetch_queue u_queue (
    .CLK         (CLK),
    .RES         (RES),
    .flush_i     (redirect),
    .push_i      (q_push),
    .push_pc_i   (pc_q),
    .push_inst_i (IDATA),
    .pop_i       (q_pop),
    .head_pc_o   (head_pc),
    .head_inst_o (head_inst),
    .count_o     (q_count)
  );

  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q   <= StIssue;
      pc_q      <= RESET_PC;
      ireq_q    <= 1'b0;
      iaddr_q   <= RESET_PC;
      if_pc_q   <= RESET_PC;
      if_inst_q <= NopInst;
    end else begin
      case (state_q)
        StIssue: begin
          if (redirect) begin
            pc_q <= target;
          end else if (can_issue) begin
            state_q <= StWait;
            ireq_q  <= 1'b1;
            iaddr_q <= pc_q;
          end
        end
        StWait: begin
          if (IACK) begin
            state_q <= StIssue;
            ireq_q  <= 1'b0;
            pc_q    <= redirect ? target : pc_q + 32'd4;
          end else if (redirect) begin
            state_q <= StDrop;
            pc_q    <= target;
          end
        end
        StDrop: begin
          // Stale request stays on the bus until memory answers it.
          if (redirect) pc_q <= target;
          if (IACK) begin
            state_q <= StIssue;
            ireq_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIssue;
          ireq_q  <= 1'b0;
        end
      endcase

      if (redirect) begin
        if_pc_q   <= target;
        if_inst_q <= NopInst;
      end else if (!HLT) begin
        if (!q_empty) begin
          if_pc_q   <= head_pc;
          if_inst_q <= head_inst;
        end else begin
          if_inst_q <= NopInst;
        end
      end
    end
  end

  assign IREQ       = ireq_q;
  assign IADDR      = iaddr_q;
  assign IF_ID_pc   = if_pc_q;
  assign IF_ID_inst = if_inst_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit against a transaction-level
// model: a queue of fetched addresses, a fetch pointer and a memory responder.
module tb_fetch_unit;

  localparam logic [31:0] RstPc = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RES = 1'b1;
  logic        HLT = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_pc = 32'h0;
  logic        IHLT = 1'b0;
  logic [31:0] ihlt_pc = 32'h0;
  logic [31:0] IADDR;
  logic        IREQ;
  logic [31:0] IDATA = 32'h0;
  logic        IACK = 1'b0;
  logic [31:0] IF_ID_pc;
  logic [31:0] IF_ID_inst;

  always #5 CLK = ~CLK;

  fetch_unit #(
    .RESET_PC (RstPc),
    .QDEPTH   (2)
  ) dut (
    .CLK          (CLK),
    .RES          (RES),
    .HLT          (HLT),
    .branch_taken (branch_taken),
    .branch_pc    (branch_pc),
    .IHLT         (IHLT),
    .ihlt_pc      (ihlt_pc),
    .IADDR        (IADDR),
    .IREQ         (IREQ),
    .IDATA        (IDATA),
    .IACK         (IACK),
    .IF_ID_pc     (IF_ID_pc),
    .IF_ID_inst   (IF_ID_inst)
  );

  int          total = 0;
  int          bad = 0;
  logic [31:0] mq[$];
  logic [31:0] emit_log[$];
  logic [31:0] fetch_pc = RstPc;
  logic [31:0] exp_if_pc = RstPc;
  logic [31:0] exp_if_inst = 32'h0;
  bit          live = 0;
  int unsigned lat = 1;
  int unsigned wait_cnt = 0;
  bit          mem_hold = 0;
  bit          mem_force = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a ^ 32'hDEAD_BEEF) * 32'd2654435761) | 32'd1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // One clock: drive memory response, advance, update model, compare.
  task automatic step();
    logic        pre_req;
    logic [31:0] pre_addr;
    logic        ack;
    logic        redir;
    logic [31:0] tgt;
    int          sz;
    ack   = mem_force || (!mem_hold && IREQ && wait_cnt >= lat);
    IACK  = ack;
    IDATA = ack ? mem_word(IADDR) : 32'h0;
    pre_req  = IREQ;
    pre_addr = IADDR;
    redir = branch_taken || IHLT;
    tgt   = branch_taken ? branch_pc : ihlt_pc;
    tgt[1:0] = 2'b00;
    @(posedge CLK);
    #1;
    if (RES) begin
      mq.delete();
      live = 0;
      fetch_pc = RstPc;
      exp_if_pc = RstPc;
      exp_if_inst = 32'h0;
      chk1("reset_ireq", IREQ, 1'b0);
      chk("reset_iaddr", IADDR, RstPc);
    end else begin
      if (redir) begin
        exp_if_pc = tgt;
        exp_if_inst = 32'h0;
      end else if (!HLT) begin
        if (mq.size() > 0) begin
          exp_if_pc = mq.pop_front();
          exp_if_inst = mem_word(exp_if_pc);
          emit_log.push_back(exp_if_pc);
        end else begin
          exp_if_inst = 32'h0;
        end
      end
      sz = mq.size();
      if (pre_req && ack) begin
        if (live && !redir) begin
          mq.push_back(pre_addr);
          fetch_pc = fetch_pc + 32'd4;
        end
        live = 0;
      end
      if (redir) begin
        mq.delete();
        fetch_pc = tgt;
        live = 0;
      end
      if (!pre_req) begin
        chk1("ireq_issue", IREQ, !redir && sz < 2);
        if (IREQ) begin
          chk("iaddr_new", IADDR, fetch_pc);
          live = 1;
        end
      end else if (!ack) begin
        chk1("ireq_hold", IREQ, 1'b1);
        chk("iaddr_hold", IADDR, pre_addr);
      end else begin
        chk1("ireq_after_ack", IREQ, 1'b0);
      end
    end
    chk("if_id_pc", IF_ID_pc, exp_if_pc);
    chk("if_id_inst", IF_ID_inst, exp_if_inst);
    if (IREQ) wait_cnt = (pre_req && !ack) ? wait_cnt + 1 : 1;
    else wait_cnt = 0;
  endtask

  task automatic wait_req(input string tag, input logic [31:0] addr, input bit match_addr);
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (IREQ && (!match_addr || IADDR == addr)) seen = 1;
      else step();
    end
    chk1(tag, seen, 1'b1);
  endtask

  task automatic wait_emits(input string tag, input int n);
    for (int i = 0; i < 60 && emit_log.size() < n; i++) step();
    chk1(tag, emit_log.size() >= n, 1'b1);
  endtask

  task automatic do_reset();
    RES = 1'b1;
    step();
    step();
    RES = 1'b0;
  endtask

  initial begin
    int          n;
    int unsigned r;
    logic [31:0] e;

    // Reset then single-cycle memory: in-order stream 0,4,8,12.
    do_reset();
    chk("reset_if_inst", IF_ID_inst, 32'h0);
    lat = 1;
    emit_log.delete();
    wait_emits("fill_emits", 4);
    for (int i = 0; i < 4; i++) begin
      e = (emit_log.size() > i) ? emit_log[i] : 32'hFFFF_FFFF;
      chk("fill_order", e, 32'(i * 4));
    end

    // Slow memory: bubbles between instructions, address stable.
    lat = 3;
    repeat (30) step();

    // Stall holds IF/ID while the queue fills, then drains back-to-back.
    do_reset();
    lat = 1;
    for (int i = 0; i < 40 && !(IF_ID_pc == 32'h8 && IF_ID_inst != 32'h0); i++) step();
    chk("hlt_reach_pc8", IF_ID_pc, 32'h8);
    HLT = 1'b1;
    repeat (5) step();
    chk("hlt_hold_pc", IF_ID_pc, 32'h8);
    chk1("hlt_full_noreq", IREQ, 1'b0);
    HLT = 1'b0;
    step();
    chk("hlt_release_12", IF_ID_pc, 32'hC);
    chk("hlt_release_12_inst", IF_ID_inst, mem_word(32'hC));
    step();
    chk("hlt_release_16", IF_ID_pc, 32'h10);
    chk("hlt_release_16_inst", IF_ID_inst, mem_word(32'h10));

    // Branch while a request is outstanding: bubble, stale response dropped.
    mem_hold = 1;
    wait_req("br_wait_req", 32'h0, 0);
    branch_taken = 1'b1;
    branch_pc = 32'h100;
    step();
    branch_taken = 1'b0;
    chk("br_bubble", IF_ID_inst, 32'h0);
    step();
    mem_hold = 0;
    emit_log.delete();
    wait_req("br_new_iaddr", 32'h100, 1);
    wait_emits("br_emit", 1);
    e = (emit_log.size() > 0) ? emit_log[0] : 32'hFFFF_FFFF;
    chk("br_first_pc", e, 32'h100);

    // Redirect latency from an idle issue state.
    for (int i = 0; i < 20 && IREQ; i++) step();
    branch_taken = 1'b1;
    branch_pc = 32'h400;
    step();
    branch_taken = 1'b0;
    n = 0;
    for (int i = 0; i < 10 && IF_ID_inst == 32'h0; i++) begin
      step();
      n++;
    end
    chk("redir_latency", 32'(n), 32'd3);
    chk("redir_latency_pc", IF_ID_pc, 32'h400);

    // Simultaneous redirects: EX target wins.
    branch_taken = 1'b1;
    branch_pc = 32'h200;
    IHLT = 1'b1;
    ihlt_pc = 32'h300;
    step();
    branch_taken = 1'b0;
    IHLT = 1'b0;
    chk("prio_if_pc", IF_ID_pc, 32'h200);
    for (int i = 0; i < 10 && IREQ; i++) step();
    wait_req("prio_req", 32'h0, 0);
    chk("prio_iaddr", IADDR, 32'h200);

    // Reset with a request outstanding and a late acknowledge.
    mem_hold = 1;
    wait_req("rst_wait_req", 32'h0, 0);
    RES = 1'b1;
    step();
    RES = 1'b0;
    mem_force = 1;
    step();
    mem_force = 0;
    mem_hold = 0;
    chk("rst_late_inst", IF_ID_inst, 32'h0);
    chk("rst_first_iaddr", IADDR, RstPc);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      lat = $urandom_range(1, 3);
      HLT = ($urandom % 4) == 0;
      r = $urandom % 100;
      branch_taken = r < 5;
      IHLT = (r >= 3) && (r < 9);
      branch_pc = (r % 2 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      ihlt_pc = $urandom;
      RES = (r == 99);
      step();
    end
    branch_taken = 1'b0;
    IHLT = 1'b0;
    HLT = 1'b0;
    RES = 1'b0;

    // PC wraps past the top of the address space.
    lat = 1;
    branch_taken = 1'b1;
    branch_pc = 32'hFFFF_FFF8;
    step();
    branch_taken = 1'b0;
    emit_log.delete();
    wait_emits("wrap_emits", 3);
    for (int i = 0; i < 3; i++) begin
      e = (emit_log.size() > i) ? emit_log[i] : 32'h1;
      chk("wrap_order", e, 32'hFFFF_FFF8 + 32'(i * 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
